// File: rtl/ldpc_3gpp_enc_rm_sel.sv
`default_nettype none
// ============================================================================
// Module   : ldpc_3gpp_enc_rm_sel
// Purpose  : Rate-matching bit selection for a 3GPP LDPC encoder. Requests a
//            finished codeword from the encoder and stores it in a circular
//            buffer. It then emits E words starting at word k0 of that buffer,
//            wrapping modulo the received length N.
// Ports    : iclk/ireset/iclkena - clock, sync active-high reset, clock enable
//            ifull/oreq            - encoder handshake (codeword ready/request)
//            isop/ival/ieop/idat/itag - codeword stream from the encoder
//            icfg_k0/icfg_e        - start word and output length, sampled at
//                                    the accepted isop
//            ireq                  - downstream ready
//            osop/oval/oeop/odat/otag - selected output stream
//            obusy/oerr            - not-idle flag, one-cycle error pulse
// Revision : 1.0 - initial release
// ============================================================================
module ldpc_3gpp_enc_rm_sel #(
  parameter int pDAT_W  = 8,
  parameter int pTAG_W  = 4,
  parameter int pADDR_W = 10,
  parameter int pE_W    = 16
) (
  input  logic               iclk,
  input  logic               ireset,
  input  logic               iclkena,
  input  logic               ifull,
  output logic               oreq,
  input  logic               isop,
  input  logic               ival,
  input  logic               ieop,
  input  logic [pDAT_W-1:0]  idat,
  input  logic [pTAG_W-1:0]  itag,
  input  logic [pADDR_W-1:0] icfg_k0,
  input  logic [pE_W-1:0]    icfg_e,
  input  logic               ireq,
  output logic               osop,
  output logic               oval,
  output logic               oeop,
  output logic [pDAT_W-1:0]  odat,
  output logic [pTAG_W-1:0]  otag,
  output logic               obusy,
  output logic               oerr
);

  localparam int               DEPTH     = 1 << pADDR_W;
  localparam logic [pADDR_W:0] DEPTH_CNT = (pADDR_W + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WRITE = 2'd2,
    ST_READ  = 2'd3
  } state_t;

  state_t state, state_nxt;

  // circular buffer (no reset needed)
  logic [pDAT_W-1:0] mem [DEPTH];
  logic [pDAT_W-1:0] rd_dat;

  // codeword context
  logic [pADDR_W-1:0] k0;
  logic [pE_W-1:0]    e_len;
  logic [pTAG_W-1:0]  tag;
  logic [pADDR_W:0]   wr_cnt;
  logic [pADDR_W:0]   n_words;
  logic               ovf;

  // read side
  logic               rd_first;
  logic [pADDR_W-1:0] rd_addr;
  logic [pE_W-1:0]    iss_cnt;
  logic               rd_vld;
  logic               rd_sop;
  logic               rd_eop;

  // two-entry output FIFO
  logic [pDAT_W-1:0]  fifo_dat [2];
  logic [1:0]         fifo_sop;
  logic [1:0]         fifo_eop;
  logic               wptr;
  logic               rptr;
  logic [1:0]         fcnt;

  logic               err;

  // combinational helpers
  logic               accept_sop;
  logic               accept_word;
  logic               wr_room;
  logic               wr_en;
  logic [pADDR_W-1:0] wr_addr;
  logic [pADDR_W:0]   wr_cnt_inc;
  logic               k0_bad;
  logic               e_zero;
  logic [pADDR_W-1:0] cur_addr;
  logic [pADDR_W-1:0] nxt_addr;
  logic               out_vld;
  logic               pop;
  logic [2:0]         occ;
  logic               issue;
  logic               head_eop;
  logic               err_nxt;
  logic               enter_read;

  assign accept_sop  = (state == ST_REQ) && ival && isop;
  assign accept_word = (state == ST_WRITE) && ival;
  // Words past the buffer capacity are dropped and the count saturates.
  assign wr_room     = wr_cnt < DEPTH_CNT;
  assign wr_en       = accept_sop || (accept_word && wr_room);
  assign wr_addr     = accept_sop ? '0 : wr_cnt[pADDR_W-1:0];
  assign wr_cnt_inc  = wr_room ? wr_cnt + 1'b1 : wr_cnt;

  assign k0_bad      = {1'b0, k0} >= n_words;
  assign e_zero      = (e_len == '0);
  // The first read address is resolved in the first READ cycle, once N is known.
  assign cur_addr    = rd_first ? (k0_bad ? '0 : k0) : rd_addr;
  assign nxt_addr    = ({1'b0, cur_addr} == n_words - 1'b1) ? '0 : cur_addr + 1'b1;

  assign out_vld     = (fcnt != 2'd0);
  assign pop         = iclkena && out_vld && ireq;
  // A read issued now lands in the FIFO one cycle later. Issue only if that
  // slot is guaranteed, counting the word already in flight and this pop.
  assign occ         = {1'b0, fcnt} + {2'b00, rd_vld} - {2'b00, pop};
  assign issue       = (state == ST_READ) && (iss_cnt < e_len) && (occ <= 3'd1);
  assign head_eop    = fifo_eop[rptr];

  assign err_nxt     = (accept_word && !wr_room && !ovf) ||
                       ((state == ST_READ) && rd_first && (k0_bad || e_zero));
  assign enter_read  = (state_nxt == ST_READ) && (state != ST_READ);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (ifull) state_nxt = ST_REQ;
      ST_REQ:   if (accept_sop) state_nxt = ieop ? ST_READ : ST_WRITE;
      ST_WRITE: if (ival && ieop) state_nxt = ST_READ;
      ST_READ:  if ((rd_first && e_zero) || (pop && head_eop)) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (iclkena) begin
      if (wr_en) mem[wr_addr] <= idat;
      if (issue) rd_dat <= mem[cur_addr];
    end
  end

  always_ff @(posedge iclk) begin
    if (ireset) begin
      state       <= ST_IDLE;
      k0          <= '0;
      e_len       <= '0;
      tag         <= '0;
      wr_cnt      <= '0;
      n_words     <= '0;
      ovf         <= 1'b0;
      rd_first    <= 1'b0;
      rd_addr     <= '0;
      iss_cnt     <= '0;
      rd_vld      <= 1'b0;
      rd_sop      <= 1'b0;
      rd_eop      <= 1'b0;
      fifo_dat[0] <= '0;
      fifo_dat[1] <= '0;
      fifo_sop    <= '0;
      fifo_eop    <= '0;
      wptr        <= 1'b0;
      rptr        <= 1'b0;
      fcnt        <= '0;
      err         <= 1'b0;
    end else if (iclkena) begin
      state <= state_nxt;
      err   <= err_nxt;

      if (accept_sop) begin
        k0     <= icfg_k0;
        e_len  <= icfg_e;
        tag    <= itag;
        wr_cnt <= (pADDR_W + 1)'(1);
        ovf    <= 1'b0;
        if (ieop) n_words <= (pADDR_W + 1)'(1);
      end

      if (accept_word) begin
        wr_cnt <= wr_cnt_inc;
        if (!wr_room) ovf <= 1'b1;
        if (ieop) n_words <= wr_cnt_inc;
      end

      rd_first <= enter_read;
      if (enter_read) iss_cnt <= '0;
      else if (issue) iss_cnt <= iss_cnt + 1'b1;

      if (state == ST_READ) rd_addr <= issue ? nxt_addr : cur_addr;

      rd_vld <= issue;
      if (issue) begin
        rd_sop <= (iss_cnt == '0);
        rd_eop <= (iss_cnt == e_len - 1'b1);
      end

      if (rd_vld) begin
        fifo_dat[wptr] <= rd_dat;
        fifo_sop[wptr] <= rd_sop;
        fifo_eop[wptr] <= rd_eop;
        wptr           <= ~wptr;
      end
      if (pop) rptr <= ~rptr;
      fcnt <= fcnt + {1'b0, rd_vld} - {1'b0, pop};
    end
  end

  assign oreq  = (state == ST_REQ) || (state == ST_WRITE);
  assign obusy = (state != ST_IDLE);
  assign oerr  = err;
  assign oval  = out_vld;
  assign osop  = out_vld && fifo_sop[rptr];
  assign oeop  = out_vld && fifo_eop[rptr];
  assign odat  = out_vld ? fifo_dat[rptr] : '0;
  assign otag  = out_vld ? tag : '0;

endmodule
`default_nettype wire

// File: tb/tb_ldpc_3gpp_enc_rm_sel.sv
`default_nettype none
// ============================================================================
// Module   : tb_ldpc_3gpp_enc_rm_sel
// Purpose  : Self-checking bench for ldpc_3gpp_enc_rm_sel. It computes the
//            expected words from k0, E and N and queues them when a codeword
//            is sent, then pops and compares them as the DUT transfers words.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ldpc_3gpp_enc_rm_sel;

  localparam int DW = 8;
  localparam int TW = 4;
  localparam int AW = 4;
  localparam int EW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, clkena, ifull, isop, ival, ieop, ireq;
  logic [DW-1:0] idat;
  logic [TW-1:0] itag;
  logic [AW-1:0] k0;
  logic [EW-1:0] e;
  logic          oreq, osop, oval, oeop, obusy, oerr;
  logic [DW-1:0] odat;
  logic [TW-1:0] otag;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int err_seen = 0;
  logic [DW+TW+1:0] exp_q [$];

  ldpc_3gpp_enc_rm_sel #(.pDAT_W(DW), .pTAG_W(TW), .pADDR_W(AW), .pE_W(EW)) dut (
    .iclk(clk), .ireset(rst), .iclkena(clkena), .ifull(ifull), .oreq(oreq),
    .isop(isop), .ival(ival), .ieop(ieop), .idat(idat), .itag(itag),
    .icfg_k0(k0), .icfg_e(e), .ireq(ireq),
    .osop(osop), .oval(oval), .oeop(oeop), .odat(odat), .otag(otag),
    .obusy(obusy), .oerr(oerr)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (oerr === 1'b1) err_seen <= err_seen + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: word i of the output is buffer[(start + i) mod n].
  task automatic push_exp(input int n, input int k0v, input int ev, input int tg, input int off);
    int start;
    start = (k0v >= n) ? 0 : k0v;
    for (int i = 0; i < ev; i++)
      exp_q.push_back({i == 0, i == ev - 1, DW'(((start + i) % n) + off), TW'(tg)});
  endtask

  task automatic send_cw(input int nw, input int k0v, input int ev, input int tg,
                         input int off, output int eop_cyc);
    int w;
    w = 0;
    ifull = 1'b1;
    while (oreq !== 1'b1 && w < 50) begin
      tick();
      w++;
    end
    n_cmp++;
    if (oreq !== 1'b1) begin
      n_bad++;
      $display("FAIL oreq_wait: oreq=%b required 1", oreq);
    end
    ifull = 1'b0;
    for (int j = 0; j < nw; j++) begin
      isop = (j == 0);
      ieop = (j == nw - 1);
      ival = 1'b1;
      idat = DW'(j + off);
      itag = TW'(tg);
      k0   = AW'(k0v);
      e    = EW'(ev);
      tick();
    end
    ival = 1'b0;
    isop = 1'b0;
    ieop = 1'b0;
    eop_cyc = cyc;
  endtask

  task automatic test_reset();
    rst = 1'b1; clkena = 1'b0; ifull = 1'b0; isop = 1'b0; ival = 1'b0; ieop = 1'b0;
    ireq = 1'b1; idat = '0; itag = '0; k0 = '0; e = '0;
    tick();
    tick();
    n_cmp++;
    if ({oreq, obusy, oerr, osop, oval, oeop, odat, otag} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h required 0",
               {oreq, obusy, oerr, osop, oval, oeop, odat, otag});
    end
    rst = 1'b0;
    ifull = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if ({oreq, obusy} !== 2'b00) begin
      n_bad++;
      $display("FAIL clkena_hold: oreq/obusy got %b required 00", {oreq, obusy});
    end
    clkena = 1'b1;
    tick();
    n_cmp++;
    if ({oreq, obusy} !== 2'b11) begin
      n_bad++;
      $display("FAIL idle_to_req: oreq/obusy got %b required 11", {oreq, obusy});
    end
    ifull = 1'b0;
  endtask

  task automatic test_read_window();
    int nt [5] = '{10, 10, 10, 1, 10};
    int kt [5] = '{3, 8, 12, 0, 9};
    int et [5] = '{5, 25, 3, 3, 1};
    for (int t = 0; t < 5; t++) begin
      int eop_cyc, first_cyc, last_cyc, e0;
      logic [DW+TW+1:0] act, expv;
      first_cyc = -1;
      last_cyc = -1;
      ireq = 1'b1;
      e0 = err_seen;
      push_exp(nt[t], kt[t], et[t], t + 1, 16 * t);
      send_cw(nt[t], kt[t], et[t], t + 1, 16 * t, eop_cyc);
      for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
        @(negedge clk);
        if (oval === 1'b1 && first_cyc < 0) first_cyc = cyc;
        if (oval === 1'b1 && ireq === 1'b1) begin
          act = {osop, oeop, odat, otag};
          expv = exp_q.pop_front();
          last_cyc = cyc;
          n_cmp++;
          if (act !== expv) begin
            n_bad++;
            $display("FAIL window[%0d] word: got %h required %h", t, act, expv);
          end
        end
        tick();
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_bad++;
        $display("FAIL window[%0d] timeout: %0d words missing, required 0", t, exp_q.size());
      end
      exp_q.delete();
      n_cmp++;
      if (first_cyc - eop_cyc != 2) begin
        n_bad++;
        $display("FAIL window[%0d] latency: got %0d required 2", t, first_cyc - eop_cyc);
      end
      n_cmp++;
      if (last_cyc - first_cyc + 1 != et[t]) begin
        n_bad++;
        $display("FAIL window[%0d] contiguous: span %0d required %0d", t,
                 last_cyc - first_cyc + 1, et[t]);
      end
      n_cmp++;
      if (err_seen - e0 != ((kt[t] >= nt[t]) ? 1 : 0)) begin
        n_bad++;
        $display("FAIL window[%0d] oerr: got %0d pulses required %0d", t, err_seen - e0,
                 (kt[t] >= nt[t]) ? 1 : 0);
      end
      n_cmp++;
      if ({obusy, oval} !== 2'b00) begin
        n_bad++;
        $display("FAIL window[%0d] idle_after: obusy/oval got %b required 00", t, {obusy, oval});
      end
    end
  endtask

  task automatic test_stall();
    int kt [2] = '{3, 8};
    int et [2] = '{5, 25};
    for (int t = 0; t < 2; t++) begin
      int eop_cyc;
      logic prev_stall;
      logic [DW+TW+2:0] prev_w;
      logic [DW+TW+1:0] act, expv;
      prev_stall = 1'b0;
      prev_w = '0;
      push_exp(10, kt[t], et[t], 9, 40);
      send_cw(10, kt[t], et[t], 9, 40, eop_cyc);
      ireq = 1'($urandom_range(0, 1));
      for (int c = 0; c < 400 && exp_q.size() > 0; c++) begin
        @(negedge clk);
        if (prev_stall) begin
          n_cmp++;
          if ({oval, osop, oeop, odat, otag} !== prev_w) begin
            n_bad++;
            $display("FAIL stall[%0d] hold: got %h required %h", t,
                     {oval, osop, oeop, odat, otag}, prev_w);
          end
        end
        prev_stall = (oval === 1'b1) && (ireq === 1'b0);
        prev_w = {oval, osop, oeop, odat, otag};
        if (oval === 1'b1 && ireq === 1'b1) begin
          act = {osop, oeop, odat, otag};
          expv = exp_q.pop_front();
          n_cmp++;
          if (act !== expv) begin
            n_bad++;
            $display("FAIL stall[%0d] word: got %h required %h", t, act, expv);
          end
        end
        tick();
        ireq = 1'($urandom_range(0, 1));
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
        n_bad++;
        $display("FAIL stall[%0d] timeout: %0d words missing, required 0", t, exp_q.size());
      end
      exp_q.delete();
      n_cmp++;
      if ({obusy, oval} !== 2'b00) begin
        n_bad++;
        $display("FAIL stall[%0d] idle_after: obusy/oval got %b required 00", t, {obusy, oval});
      end
      ireq = 1'b1;
    end
  endtask

  task automatic test_e_zero();
    int eop_cyc, e0, nval;
    e0 = err_seen;
    nval = 0;
    send_cw(10, 0, 0, 3, 0, eop_cyc);
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (oval === 1'b1) nval++;
      tick();
    end
    n_cmp++;
    if (nval != 0) begin
      n_bad++;
      $display("FAIL e_zero oval: got %0d words required 0", nval);
    end
    n_cmp++;
    if (err_seen - e0 != 1) begin
      n_bad++;
      $display("FAIL e_zero oerr: got %0d pulses required 1", err_seen - e0);
    end
    n_cmp++;
    if (obusy !== 1'b0) begin
      n_bad++;
      $display("FAIL e_zero idle: obusy got %b required 0", obusy);
    end
  endtask

  task automatic test_overflow();
    int eop_cyc, e0;
    logic [DW+TW+1:0] act, expv;
    e0 = err_seen;
    push_exp(16, 0, 16, 5, 100);
    send_cw(20, 0, 16, 5, 100, eop_cyc);
    for (int c = 0; c < 200 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (oval === 1'b1 && ireq === 1'b1) begin
        act = {osop, oeop, odat, otag};
        expv = exp_q.pop_front();
        n_cmp++;
        if (act !== expv) begin
          n_bad++;
          $display("FAIL overflow word: got %h required %h", act, expv);
        end
      end
      tick();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL overflow timeout: %0d words missing, required 0", exp_q.size());
    end
    exp_q.delete();
    n_cmp++;
    if (err_seen - e0 != 1) begin
      n_bad++;
      $display("FAIL overflow oerr: got %0d pulses required 1", err_seen - e0);
    end
  endtask

  task automatic test_reset_mid_read();
    int eop_cyc, pops, bad_idle;
    logic [DW+TW+1:0] act, expv;
    pops = 0;
    bad_idle = 0;
    push_exp(10, 0, 8, 6, 30);
    send_cw(10, 0, 8, 6, 30, eop_cyc);
    for (int c = 0; c < 50 && pops < 2; c++) begin
      @(negedge clk);
      if (oval === 1'b1 && ireq === 1'b1) begin
        act = {osop, oeop, odat, otag};
        expv = exp_q.pop_front();
        pops++;
        n_cmp++;
        if (act !== expv) begin
          n_bad++;
          $display("FAIL rst_read word: got %h required %h", act, expv);
        end
      end
      tick();
    end
    n_cmp++;
    if (pops != 2) begin
      n_bad++;
      $display("FAIL rst_read pre_words: got %0d required 2", pops);
    end
    rst = 1'b1;
    tick();
    n_cmp++;
    if ({oreq, obusy, oerr, osop, oval, oeop, odat, otag} !== '0) begin
      n_bad++;
      $display("FAIL rst_read outputs: got %h required 0",
               {oreq, obusy, oerr, osop, oval, oeop, odat, otag});
    end
    rst = 1'b0;
    exp_q.delete();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (oval !== 1'b0 || obusy !== 1'b0) bad_idle++;
      tick();
    end
    n_cmp++;
    if (bad_idle != 0) begin
      n_bad++;
      $display("FAIL rst_read residue: got %0d active cycles required 0", bad_idle);
    end
    push_exp(10, 5, 4, 7, 50);
    send_cw(10, 5, 4, 7, 50, eop_cyc);
    for (int c = 0; c < 100 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      if (oval === 1'b1 && ireq === 1'b1) begin
        act = {osop, oeop, odat, otag};
        expv = exp_q.pop_front();
        n_cmp++;
        if (act !== expv) begin
          n_bad++;
          $display("FAIL rst_read next word: got %h required %h", act, expv);
        end
      end
      tick();
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL rst_read next timeout: %0d words missing, required 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_read_window();
    test_stall();
    test_e_zero();
    test_overflow();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
